// File: rtl/apb4_mem_slave_pkg.sv
// Shared types and helpers for the APB4 memory completer: FSM state encoding,
// wait-counter width and memory index width derivation.
package apb4_mem_slave_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   localparam int WCNT_W = 4;

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/apb4_mem_slave_sram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// A write cycle leaves the read register untouched.
module sp_sram_be #(
   parameter int DEPTH = 64,
   parameter int DW    = 32,
   parameter int IW    = 6
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [DW/8-1:0]   be,
   input  logic [IW-1:0]     addr,
   input  logic [DW-1:0]     wdata,
   output logic [DW-1:0]     rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < DW/8; i++) begin
               if (be[i]) begin
                  mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 completer in front of a word RAM: wait-state insertion, address/alignment
// error decode and byte-strobed writes committed at the end of the ready cycle.
module apb4_mem_slave
   import apb4_mem_slave_pkg::*;
#(
   parameter int AW          = 8,
   parameter int DW          = 32,
   parameter int MEM_DEPTH   = 64,
   parameter int WAIT_STATES = 0
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [AW-1:0]     paddr,
   input  logic [DW-1:0]     pwdata,
   input  logic [DW/8-1:0]   pstrb,
   input  logic [2:0]        pprot,
   output logic [DW-1:0]     prdata,
   output logic              pready,
   output logic              pslverr
);

   localparam int IW = idx_width(MEM_DEPTH);

   state_e              state_q, state_d;
   logic [WCNT_W-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic                wr_q, wr_d;
   logic                err_q, err_d;

   logic [AW-3:0]       pidx;
   logic                addr_err;
   logic                ram_en;
   logic                ram_we;
   logic [IW-1:0]       ram_addr;
   logic [DW-1:0]       ram_rdata;
   logic                unused_ok;

   assign unused_ok = &{1'b0, pprot, 1'b0};

   assign pidx     = paddr[AW-1:2];
   assign addr_err = (paddr[1:0] != 2'b00) || (32'(pidx) >= 32'(MEM_DEPTH));

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
      end
   end

   // RAM is read at the setup edge and written at the edge closing the ready cycle
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      wr_d     = wr_q;
      err_d    = err_q;
      ram_en   = 1'b0;
      ram_we   = 1'b0;
      ram_addr = pidx[IW-1:0];
      case (state_q)
         IDLE: begin
            if (psel && !penable) begin
               state_d = ACCESS;
               cnt_d   = WCNT_W'(WAIT_STATES);
               idx_d   = pidx[IW-1:0];
               wr_d    = pwrite;
               err_d   = addr_err;
               ram_en  = !addr_err && !pwrite;
            end
         end
         ACCESS: begin
            if (!psel) begin
               state_d = IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = IDLE;
               if (wr_q && !err_q) begin
                  ram_en   = 1'b1;
                  ram_we   = 1'b1;
                  ram_addr = idx_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   sp_sram_be #(
      .DEPTH (MEM_DEPTH),
      .DW    (DW),
      .IW    (IW)
   ) u_sram (
      .clk   (pclk),
      .en    (ram_en),
      .we    (ram_we),
      .be    (pstrb),
      .addr  (ram_addr),
      .wdata (pwdata),
      .rdata (ram_rdata)
   );

   assign pready  = (state_q == ACCESS) && (cnt_q == '0);
   assign pslverr = pready && err_q;
   assign prdata  = (pready && !wr_q && !err_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed + randomized bench for apb4_mem_slave: three instances with 0, 3 and 5
// wait states checked against a word-array reference model.
module tb_apb4_mem_slave;

   localparam int NI = 3;

   logic                 pclk = 1'b0;
   logic                 presetn;
   logic [NI-1:0]        psel_v;
   logic                 penable;
   logic                 pwrite;
   logic [8:0]           paddr;
   logic [31:0]          pwdata;
   logic [3:0]           pstrb;
   logic [2:0]           pprot;
   logic [NI-1:0][31:0]  prdata_v;
   logic [NI-1:0]        pready_v;
   logic [NI-1:0]        pslverr_v;

   int checks = 0;
   int passed = 0;

   logic [31:0] mdl [NI][64];

   always #5 pclk = ~pclk;

   for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      apb4_mem_slave #(
         .AW          (9),
         .DW          (32),
         .MEM_DEPTH   (64),
         .WAIT_STATES ((gi == 0) ? 0 : ((gi == 1) ? 3 : 5))
      ) u_dut (
         .pclk    (pclk),
         .presetn (presetn),
         .psel    (psel_v[gi]),
         .penable (penable),
         .pwrite  (pwrite),
         .paddr   (paddr),
         .pwdata  (pwdata),
         .pstrb   (pstrb),
         .pprot   (pprot),
         .prdata  (prdata_v[gi]),
         .pready  (pready_v[gi]),
         .pslverr (pslverr_v[gi])
      );
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
   endfunction

   function automatic bit addr_bad(input logic [8:0] a);
      return (a[1:0] != 2'b00) || (a[8:2] >= 7'd64);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One complete transfer; entered and left 1 time unit after a rising edge.
   task automatic xfer(input int d, input bit wr, input logic [8:0] a,
                       input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rd);
      int   waits;
      bit   done;
      bit   err;
      logic [31:0] exp_rd;
      err    = addr_bad(a);
      exp_rd = (!wr && !err) ? mdl[d][a[7:2]] : 32'h0;
      psel_v    = '0;
      psel_v[d] = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = a;
      pwdata  = wd;
      pstrb   = st;
      pprot   = 3'($urandom_range(0, 7));
      @(negedge pclk);
      check("setup_pready", 32'(pready_v[d]), 32'h0);
      @(posedge pclk);
      #1 penable = 1'b1;
      waits = 0;
      done  = 1'b0;
      rd    = 32'h0;
      while (!done) begin
         @(negedge pclk);
         if (pready_v[d]) begin
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 20) begin
               check("pready_timeout", 32'(waits), 32'd20);
               break;
            end
            @(posedge pclk);
            #1;
         end
      end
      if (done) begin
         check("wait_count", 32'(waits), 32'(ws_of(d)));
         check("pslverr", 32'(pslverr_v[d]), 32'(err));
         check("prdata", prdata_v[d], exp_rd);
         rd = prdata_v[d];
         if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
               if (st[b]) mdl[d][a[7:2]][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end
      $display("xfer inst=%0d %s addr=%h wdata=%h strb=%h rdata=%h err=%0b waits=%0d",
               d, wr ? "WR" : "RD", a, wd, st, rd, err, waits);
      @(posedge pclk);
      #1;
      psel_v  = '0;
      penable = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [31:0] wd;
      logic [8:0]  a;
      logic [31:0] old20;

      presetn = 1'b0;
      psel_v  = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      pprot   = '0;
      repeat (3) @(posedge pclk);
      @(negedge pclk);
      for (int d = 0; d < NI; d++) begin
         check("rst_pready", 32'(pready_v[d]), 32'h0);
         check("rst_pslverr", 32'(pslverr_v[d]), 32'h0);
         check("rst_prdata", prdata_v[d], 32'h0);
      end
      @(posedge pclk);
      #1 presetn = 1'b1;

      // Fill every word so later reads have defined expectations
      for (int d = 0; d < NI; d++) begin
         for (int i = 0; i < 64; i++) begin
            xfer(d, 1'b1, 9'(i * 4), $urandom, 4'hF, rd);
         end
      end

      // Full-word write then read back, no wait states
      xfer(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, rd);
      xfer(0, 1'b0, 9'h010, 32'h0, 4'h0, rd);
      check("t1_readback", rd, 32'hDEADBEEF);

      // Partial byte strobes
      xfer(0, 1'b1, 9'h004, 32'h11223344, 4'hF, rd);
      xfer(0, 1'b1, 9'h004, 32'hAABBCCDD, 4'b0101, rd);
      xfer(0, 1'b0, 9'h004, 32'h0, 4'h0, rd);
      check("t2_strobes", rd, 32'h11BB33DD);

      // Wait states: latency checked inside every transfer
      xfer(1, 1'b0, 9'(($urandom_range(0, 63)) * 4), 32'h0, 4'h0, rd);
      xfer(1, 1'b1, 9'h030, 32'hCAFEF00D, 4'hF, rd);
      xfer(1, 1'b0, 9'h030, 32'h0, 4'h0, rd);
      check("t3_readback", rd, 32'hCAFEF00D);

      // Error responses and their side-effect freedom
      for (int d = 0; d < 2; d++) begin
         xfer(d, 1'b0, 9'h102, 32'h0, 4'h0, rd);
         xfer(d, 1'b1, 9'h100, 32'h12345678, 4'hF, rd);
         xfer(d, 1'b1, 9'h00E, 32'h87654321, 4'hF, rd);
         xfer(d, 1'b1, 9'h0FC, 32'h0BADF00D, 4'hF, rd);
         xfer(d, 1'b0, 9'h0FC, 32'h0, 4'h0, rd);
         check("t4_last_word", rd, 32'h0BADF00D);
         xfer(d, 1'b0, 9'h00C, 32'h0, 4'h0, rd);
         xfer(d, 1'b0, 9'h000, 32'h0, 4'h0, rd);
         xfer(d, 1'b1, 9'h018, 32'hFFFFFFFF, 4'h0, rd);
         xfer(d, 1'b0, 9'h018, 32'h0, 4'h0, rd);
      end

      // Reset during the second wait cycle of a write aborts it
      old20     = mdl[2][8];
      psel_v    = 3'b100;
      penable   = 1'b0;
      pwrite    = 1'b1;
      paddr     = 9'h020;
      pwdata    = ~old20;
      pstrb     = 4'hF;
      @(posedge pclk);
      #1 penable = 1'b1;
      @(negedge pclk);
      @(posedge pclk);
      #1;
      @(negedge pclk);
      presetn = 1'b0;
      @(posedge pclk);
      @(negedge pclk);
      check("t5_rst_pready", 32'(pready_v[2]), 32'h0);
      check("t5_rst_pslverr", 32'(pslverr_v[2]), 32'h0);
      psel_v  = '0;
      penable = 1'b0;
      presetn = 1'b1;
      @(posedge pclk);
      #1;
      xfer(2, 1'b0, 9'h020, 32'h0, 4'h0, rd);
      check("t5_mem_kept", rd, old20);

      // Back-to-back write/read pairs to the same address
      for (int d = 0; d < NI; d++) begin
         for (int k = 0; k < 4; k++) begin
            a  = 9'($urandom_range(0, 63) * 4);
            wd = $urandom;
            xfer(d, 1'b1, a, wd, 4'($urandom_range(0, 15)), rd);
            xfer(d, 1'b0, a, 32'h0, 4'h0, rd);
         end
      end

      // Random mixed traffic, occasionally misaligned or out of range
      for (int n = 0; n < 60; n++) begin
         a = 9'($urandom_range(0, 70) * 4);
         if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
         xfer(n % NI, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), rd);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
